// File: rtl/seq_mult_param_pkg.sv
// seq_mult_param_pkg: shared state encoding and sizing helper for the shift-add multiplier
package seq_mult_param_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Bits needed to count 0..value-1; never less than one so the counter always exists
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_mult_param_twos_abs.sv
// twos_abs: magnitude and sign of an operand, treating it as two's complement only when enabled
module twos_abs
    import seq_mult_param_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic [WIDTH-1:0] magnitude,
    output logic             sign
);

    // The most negative value negates to itself, which read unsigned is exactly its magnitude
    assign sign      = enable & value[WIDTH-1];
    assign magnitude = sign ? (~value + 1'b1) : value;

endmodule

// File: rtl/seq_mult_param.sv
// seq_mult_param: fixed-latency signed/unsigned shift-add multiplier with busy and done pulse
module seq_mult_param
    import seq_mult_param_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_sig,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done_sig,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = clog2(WIDTH);

    logic [1:0]           state;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand_mag;
    logic                 neg;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH:0]       sum;
    logic                 accept;

    twos_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value     (multiplicand),
        .enable    (signed_mode),
        .magnitude (mag_a),
        .sign      (sign_a)
    );

    twos_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value     (multiplier),
        .enable    (signed_mode),
        .magnitude (mag_b),
        .sign      (sign_b)
    );

    // Upper half plus the conditionally added multiplicand; the carry is kept and shifted in
    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_mag} : '0);
    // A start in the done cycle is taken so held requests run back to back
    assign accept = start_sig && (state == ST_IDLE || state == ST_DONE);

    // Control FSM and datapath: load, WIDTH shift-add steps, sign fix-up, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done_sig  <= 1'b0;
            product   <= '0;
            acc       <= '0;
            mcand_mag <= '0;
            neg       <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_sig <= 1'b0;
                    if (accept) begin
                        state     <= ST_CALC;
                        busy      <= 1'b1;
                        acc       <= {{WIDTH{1'b0}}, mag_b};
                        mcand_mag <= mag_a;
                        neg       <= sign_a ^ sign_b;
                        count     <= '0;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc   <= {sum, acc[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= ST_SIGN;
                end
                ST_SIGN: begin
                    product  <= neg ? (~acc + 1'b1) : acc;
                    done_sig <= 1'b1;
                    state    <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed vectors plus timing, reset and 16-bit sweep checks
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;
    logic        st16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] prod16;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_sig(st8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .busy(busy8), .done_sig(done8), .product(prod8)
    );

    seq_mult_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start_sig(st16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16),
        .busy(busy16), .done_sig(done16), .product(prod16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One operation on the chosen instance; returns product and done latency in edges after E0
    task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sm,
                      output logic [31:0] p, output int lat);
        @(negedge clk);
        if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; st8 = 1'b1; end
        else begin a16 = a; b16 = b; sm16 = sm; st16 = 1'b1; end
        @(posedge clk);
        #1;
        st8 = 1'b0;
        st16 = 1'b0;
        a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16;
        lat = -1;
        p = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if ((w == 8) ? done8 : done16) begin
                lat = i;
                p = (w == 8) ? {16'b0, prod8} : prod16;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        int lat, d1, d2;
        logic [31:0] p1, p2;
        logic [15:0] ra, rb;
        logic rsm;
        logic [31:0] ea, eb;

        vecs[0]  = '{8'hF9, 8'h0D, 1'b1, 16'hFFA5};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[4]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[5]  = '{8'h00, 8'h85, 1'b1, 16'h0000};
        vecs[6]  = '{8'h85, 8'h00, 1'b1, 16'h0000};
        vecs[7]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
        vecs[8]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[9]  = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
        vecs[10] = '{8'h0C, 8'h0A, 1'b0, 16'h0078};
        vecs[11] = '{8'h80, 8'hFF, 1'b1, 16'h0080};
        vecs[12] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};

        #1;
        chk("reset_busy", {31'b0, busy8}, 32'd0);
        chk("reset_done", {31'b0, done8}, 32'd0);
        chk("reset_product", {16'b0, prod8}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            op(8, {8'b0, vecs[i].a}, {8'b0, vecs[i].b}, vecs[i].sm, p, lat);
            chk($sformatf("vec%0d_product", i), p, {16'b0, vecs[i].exp});
            chk($sformatf("vec%0d_latency", i), lat, 32'd9);
        end

        // Cycle-exact busy/done profile for -7 * 13
        @(negedge clk);
        a8 = 8'hF9; b8 = 8'h0D; sm8 = 1'b1; st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        chk("profile_busy_e0", {31'b0, busy8}, 32'd1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("profile_busy_e%0d", i), {31'b0, busy8}, (i <= 9) ? 32'd1 : 32'd0);
            chk($sformatf("profile_done_e%0d", i), {31'b0, done8}, (i == 9) ? 32'd1 : 32'd0);
            if (i == 9) chk("profile_product", {16'b0, prod8}, 32'h0000FFA5);
        end

        // Start reasserted at E0+3 with other operands must be ignored
        @(negedge clk);
        a8 = 8'hF9; b8 = 8'h0D; sm8 = 1'b1; st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        d1 = -1;
        p1 = 'x;
        for (int i = 1; i <= 12; i++) begin
            if (i == 3) begin a8 = 8'h10; b8 = 8'h10; sm8 = 1'b0; st8 = 1'b1; end
            @(posedge clk);
            #1;
            if (i == 3) st8 = 1'b0;
            if (done8 && d1 < 0) begin d1 = i; p1 = {16'b0, prod8}; end
        end
        chk("ignore_latency", d1, 32'd9);
        chk("ignore_product", p1, 32'h0000FFA5);

        // Start held high: operations back to back, operands changed after the first sample
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h05; sm8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1;
        a8 = 8'h06; b8 = 8'h07;
        d1 = -1; d2 = -1; p1 = 'x; p2 = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done8 && d1 < 0) begin d1 = i; p1 = {16'b0, prod8}; end
            else if (done8 && d2 < 0) begin d2 = i; p2 = {16'b0, prod8}; end
        end
        st8 = 1'b0;
        chk("b2b_first_done", d1, 32'd9);
        chk("b2b_first_product", p1, 32'h0000000F);
        chk("b2b_second_done", d2, 32'd19);
        chk("b2b_second_product", p2, 32'h0000002A);
        repeat (14) @(posedge clk);
        #1;
        chk("b2b_idle_after", {31'b0, busy8}, 32'd0);

        // Reset dropped at E0+4 clears everything at once and no done pulse follows
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h05; sm8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, busy8}, 32'd0);
        chk("rst_mid_done", {31'b0, done8}, 32'd0);
        chk("rst_mid_product", {16'b0, prod8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d1 = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done8) d1++;
        end
        chk("rst_no_done_pulse", d1, 32'd0);
        op(8, 16'h00F9, 16'h000D, 1'b1, p, lat);
        chk("rst_fresh_product", p, 32'h0000FFA5);
        chk("rst_fresh_latency", lat, 32'd9);

        // 16-bit sweep against a sign-extended reference multiply
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rsm = 1'($urandom);
            if (i % 50 == 0) ra = '0;
            if (i % 50 == 25) rb = '0;
            if (i == 1) begin ra = 16'h8000; rb = 16'h8000; rsm = 1'b1; end
            if (i == 2) begin ra = 16'hFFFF; rb = 16'hFFFF; rsm = 1'b0; end
            ea = rsm ? {{16{ra[15]}}, ra} : {16'b0, ra};
            eb = rsm ? {{16{rb[15]}}, rb} : {16'b0, rb};
            op(16, ra, rb, rsm, p, lat);
            chk($sformatf("w16_op%0d_product", i), p, ea * eb);
            if (lat != 17) chk($sformatf("w16_op%0d_latency", i), lat, 32'd17);
        end
        chk("w16_final_latency", lat, 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
